// File: rtl/de1_arm_nios_led_fader_if.sv
// LED fader bus: on/off requests and mode in, PWM drive and status out.
interface de1_arm_nios_led_fader_if #(
  parameter int NUM_LEDS = 10
);
  logic [NUM_LEDS-1:0] led_in;
  logic                fade_en;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;

  modport master (output led_in, output fade_en, input led_out, input busy);
  modport slave  (input led_in, input fade_en, output led_out, output busy);
endinterface

// File: rtl/de1_arm_nios_led_fader.sv
// LED fader: turns plain on/off PIO bits into gradual PWM brightness ramps.
// Each LED has its own brightness level that walks one step per prescaler
// tick toward its target; a single shared counter produces the PWM.
module de1_arm_nios_led_fader #(
  parameter int NUM_LEDS = 10,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000
) (
  input logic                   clk,
  input logic                   reset,
  de1_arm_nios_led_fader_if.slave bus
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [NUM_LEDS-1:0] led_in_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] level [NUM_LEDS];
  logic [PWM_BITS-1:0] target [NUM_LEDS];
  logic                step_tick;
  logic [NUM_LEDS-1:0] out_d;
  logic                busy_d;

  // Targets, step tick, next PWM drive and busy condition from current state
  always_comb begin
    step_tick = (prescaler == PRE_LAST);
    busy_d    = 1'b0;
    out_d     = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      target[i] = led_in_q[i] ? MAX : '0;
      out_d[i]  = (level[i] == MAX) || (pwm_cnt < level[i]);
      if (level[i] != target[i]) busy_d = 1'b1;
    end
  end

  // Input register plus free-running PWM counter and step prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      led_in_q  <= '0;
      pwm_cnt   <= '0;
      prescaler <= '0;
    end else begin
      led_in_q  <= bus.led_in;
      pwm_cnt   <= pwm_cnt + 1'b1;
      prescaler <= step_tick ? '0 : prescaler + 1'b1;
    end
  end

  // Per-LED brightness: snap in bypass, otherwise one saturating step per tick
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) level[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (!bus.fade_en) begin
          level[i] <= target[i];
        end else if (step_tick) begin
          if (level[i] < target[i]) level[i] <= level[i] + 1'b1;
          else if (level[i] > target[i]) level[i] <= level[i] - 1'b1;
        end
      end
    end
  end

  // Registered PWM pin drive and busy status
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.led_out <= '0;
      bus.busy    <= 1'b0;
    end else begin
      bus.led_out <= out_d;
      bus.busy    <= busy_d;
    end
  end

endmodule
